// File: rtl/gpio_pkg.sv
// Shared constants, legal parameter ranges and sizing helper for the GPIO input conditioner.
// Latency: none (package only). Backpressure: not applicable.
// Build option GPIO_EDGE_DETECT_EN adds per-bit rise/fall pulses in the conditioner.
package gpio_pkg;

    localparam logic GPIO_TRI_INPUT      = 1'b1;
    localparam int   SYNC_STAGES_MIN     = 2;
    localparam int   SYNC_STAGES_MAX     = 4;
    localparam int   DEBOUNCE_CYCLES_MIN = 1;

    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic bit params_legal(input int sync_stages, input int debounce_cycles);
        return (sync_stages >= SYNC_STAGES_MIN) && (sync_stages <= SYNC_STAGES_MAX) &&
               (debounce_cycles >= DEBOUNCE_CYCLES_MIN);
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO bit: synchroniser chain, debounce counter, level flop (+ rise/fall with GPIO_EDGE_DETECT_EN).
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from pin step to level.
// Backpressure: none; chg_term is the combinational next^current change term.
module gpio_debounce_bit
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    input  logic tri_in,
    output logic level,
    output logic chg_term
`ifdef GPIO_EDGE_DETECT_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    localparam int              CNT_W    = clog2_f(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_d;
    logic                   sync_b;

    assign sync_b = sync_q[SYNC_STAGES-1];

    // Any matching sample clears the count, so only an unbroken mismatch run is accepted.
    always_comb begin
        level_d = level;
        cnt_d   = '0;
        if (tri_in != GPIO_TRI_INPUT) begin
            level_d = 1'b0;
        end else if (sync_b != level) begin
            if (cnt_q == CNT_LAST) level_d = sync_b;
            else                   cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    assign chg_term = level_d ^ level;

    // The chain is never masked so it stays primed across direction changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            level  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            cnt_q  <= cnt_d;
            level  <= level_d;
        end
    end

`ifdef GPIO_EDGE_DETECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= ~level & level_d;
            fall <= level & ~level_d;
        end
    end
`endif

endmodule

// File: rtl/gpio_input_cond.sv
// Conditions async GPIO pins for up_gpio: sync, per-bit debounce, output masking, change pulse.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges pin-to-gpio_o; masking takes effect next edge.
// Backpressure: none. GPIO_EDGE_DETECT_EN adds gpio_rise/gpio_fall aligned with gpio_chg.
module gpio_input_cond
    import gpio_pkg::*;
#(
    parameter int GPIO_WIDTH      = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [GPIO_WIDTH-1:0] gpio_pin_i,
    input  logic [GPIO_WIDTH-1:0] gpio_t_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic                  gpio_chg
`ifdef GPIO_EDGE_DETECT_EN
    ,
    output logic [GPIO_WIDTH-1:0] gpio_rise,
    output logic [GPIO_WIDTH-1:0] gpio_fall
`endif
);

    if (!params_legal(SYNC_STAGES, DEBOUNCE_CYCLES)) begin : g_bad_params
        $error("gpio_input_cond: SYNC_STAGES must be 2..4 and DEBOUNCE_CYCLES >= 1");
    end

    logic [GPIO_WIDTH-1:0] chg_terms;

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_bit
        gpio_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk     (clk),
            .rst     (rst),
            .pin     (gpio_pin_i[i]),
            .tri_in  (gpio_t_i[i]),
            .level   (gpio_o[i]),
            .chg_term(chg_terms[i])
`ifdef GPIO_EDGE_DETECT_EN
            ,
            .rise    (gpio_rise[i]),
            .fall    (gpio_fall[i])
`endif
        );
    end

    // Simultaneous changes on several bits collapse into one pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) gpio_chg <= 1'b0;
        else     gpio_chg <= |chg_terms;
    end

endmodule

// File: tb/tb_gpio_input_cond.sv
// Bench for gpio_input_cond: directed scenarios plus randomized pins/masks vs a history-based model.
module tb_gpio_input_cond;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] gpio_pin_i = '0;
    logic [W-1:0] gpio_t_i = '1;
    logic [W-1:0] gpio_o;
    logic         gpio_chg;
`ifdef GPIO_EDGE_DETECT_EN
    logic [W-1:0] gpio_rise;
    logic [W-1:0] gpio_fall;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gpio_input_cond #(
        .GPIO_WIDTH     (W),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gpio_pin_i(gpio_pin_i),
        .gpio_t_i  (gpio_t_i),
        .gpio_o    (gpio_o),
        .gpio_chg  (gpio_chg)
`ifdef GPIO_EDGE_DETECT_EN
        ,
        .gpio_rise (gpio_rise),
        .gpio_fall (gpio_fall)
`endif
    );

    // Reference model: pin samples arrive SYNC edges late; a bit takes the new level once the
    // last DEB delayed samples since its last restart all disagree with the current level.
    logic [W-1:0] m_pin_hist  [SYNC];
    logic [W-1:0] m_sync_hist [DEB];
    int           m_age       [W];
    logic [W-1:0] m_lvl, m_rise, m_fall, m_s, m_nl;
    logic         m_chg;
    bit           m_diff;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC; i++) m_pin_hist[i] = '0;
            for (int i = 0; i < DEB; i++)  m_sync_hist[i] = '0;
            for (int k = 0; k < W; k++)    m_age[k] = 0;
            m_lvl = '0; m_chg = 1'b0; m_rise = '0; m_fall = '0;
        end else begin
            m_s = m_pin_hist[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) m_pin_hist[i] = m_pin_hist[i-1];
            m_pin_hist[0] = gpio_pin_i;
            for (int i = DEB - 1; i > 0; i--) m_sync_hist[i] = m_sync_hist[i-1];
            m_sync_hist[0] = m_s;
            m_nl = m_lvl;
            for (int k = 0; k < W; k++) begin
                if (!gpio_t_i[k]) begin
                    m_nl[k]  = 1'b0;
                    m_age[k] = 0;
                end else begin
                    if (m_age[k] < DEB) m_age[k]++;
                    m_diff = 1'b1;
                    for (int j = 0; j < DEB; j++)
                        if (m_sync_hist[j][k] == m_lvl[k]) m_diff = 1'b0;
                    if (m_age[k] >= DEB && m_diff) begin
                        m_nl[k]  = m_s[k];
                        m_age[k] = 0;
                    end
                end
            end
            m_chg  = |(m_nl ^ m_lvl);
            m_rise = ~m_lvl & m_nl;
            m_fall = m_lvl & ~m_nl;
            m_lvl  = m_nl;
        end
    end

    task automatic test_reset();
        int seen;
        rst = 1'b1; gpio_pin_i = '0; gpio_t_i = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (gpio_o !== '0 || gpio_chg !== 1'b0) begin
            n_err++; $display("FAIL reset_state: gpio_o=%h chg=%b, required 00/0", gpio_o, gpio_chg);
        end
        gpio_pin_i = 8'hFF;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (gpio_o !== 8'hFF) begin
            n_err++; $display("FAIL pre_reset_level: gpio_o=%h, required ff", gpio_o);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (gpio_o !== '0 || gpio_chg !== 1'b0) begin
            n_err++; $display("FAIL async_reset: gpio_o=%h chg=%b, required 00/0", gpio_o, gpio_chg);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (gpio_o !== '0) begin seen = i; break; end
        end
        n_cmp++;
        if (seen != SYNC + DEB) begin
            n_err++; $display("FAIL reset_release_latency: first update at edge %0d, required %0d", seen, SYNC + DEB);
        end
    endtask

    task automatic settle_low();
        gpio_pin_i = '0; gpio_t_i = '1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_step();
        settle_low();
        gpio_pin_i = 8'h01;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if (gpio_o !== ((i >= SYNC + DEB) ? 8'h01 : 8'h00) || gpio_chg !== (i == SYNC + DEB)) begin
                n_err++; $display("FAIL step edge %0d: gpio_o=%h chg=%b", i, gpio_o, gpio_chg);
            end
`ifdef GPIO_EDGE_DETECT_EN
            n_cmp++;
            if (gpio_rise !== ((i == SYNC + DEB) ? 8'h01 : 8'h00) || gpio_fall !== 8'h00) begin
                n_err++; $display("FAIL step_edges edge %0d: rise=%h fall=%h", i, gpio_rise, gpio_fall);
            end
`endif
        end
    endtask

    task automatic test_glitch();
        int chg_cnt, high_cnt;
        settle_low();
        chg_cnt = 0;
        gpio_pin_i = 8'h01;
        repeat (DEB - 1) @(negedge clk);
        gpio_pin_i = 8'h00;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (gpio_chg) chg_cnt++;
            n_cmp++;
            if (gpio_o !== 8'h00) begin
                n_err++; $display("FAIL glitch_short: gpio_o=%h, required 00", gpio_o);
            end
        end
        n_cmp++;
        if (chg_cnt != 0) begin
            n_err++; $display("FAIL glitch_short_chg: %0d pulses, required 0", chg_cnt);
        end
        high_cnt = 0;
        gpio_pin_i = 8'h01;
        repeat (DEB) begin
            @(negedge clk);
            if (gpio_o[0]) high_cnt++;
        end
        gpio_pin_i = 8'h00;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (gpio_o[0]) high_cnt++;
            n_cmp++;
            if (gpio_o !== m_lvl) begin
                n_err++; $display("FAIL glitch_long_model: gpio_o=%h, model %h", gpio_o, m_lvl);
            end
        end
        n_cmp++;
        if (high_cnt != DEB) begin
            n_err++; $display("FAIL glitch_long_width: high %0d cycles, required %0d", high_cnt, DEB);
        end
    endtask

    task automatic test_mask();
        settle_low();
        gpio_pin_i = 8'hF0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (gpio_o !== 8'hF0) begin
            n_err++; $display("FAIL mask_pre: gpio_o=%h, required f0", gpio_o);
        end
        gpio_t_i = 8'h0F;
        @(negedge clk);
        n_cmp++;
        if (gpio_o !== 8'h00 || gpio_chg !== 1'b1) begin
            n_err++; $display("FAIL mask_apply: gpio_o=%h chg=%b, required 00/1", gpio_o, gpio_chg);
        end
`ifdef GPIO_EDGE_DETECT_EN
        n_cmp++;
        if (gpio_fall !== 8'hF0 || gpio_rise !== 8'h00) begin
            n_err++; $display("FAIL mask_fall: fall=%h rise=%h, required f0/00", gpio_fall, gpio_rise);
        end
`endif
        @(negedge clk);
        n_cmp++;
        if (gpio_chg !== 1'b0) begin
            n_err++; $display("FAIL mask_chg_width: chg=%b, required 0", gpio_chg);
        end
        repeat (3) @(negedge clk);
        gpio_t_i = 8'hFF;
        for (int i = 1; i <= DEB + 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (gpio_o !== ((i >= DEB) ? 8'hF0 : 8'h00)) begin
                n_err++; $display("FAIL mask_release edge %0d: gpio_o=%h", i, gpio_o);
            end
        end
    endtask

    task automatic test_multi_bit();
        int chg_cnt;
        settle_low();
        chg_cnt = 0;
        gpio_pin_i = 8'hA5;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (gpio_chg) chg_cnt++;
            n_cmp++;
            if (gpio_o !== 8'h00 && gpio_o !== 8'hA5) begin
                n_err++; $display("FAIL multi_partial: gpio_o=%h", gpio_o);
            end
        end
        n_cmp++;
        if (gpio_o !== 8'hA5 || chg_cnt != 1) begin
            n_err++; $display("FAIL multi_final: gpio_o=%h pulses=%0d, required a5/1", gpio_o, chg_cnt);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) gpio_pin_i = W'($urandom);
            else gpio_pin_i = gpio_pin_i ^ W'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) gpio_t_i = W'($urandom | $urandom);
            if ($urandom_range(0, 40) == 0) gpio_t_i = '1;
            @(negedge clk);
            n_cmp++;
            if (gpio_o !== m_lvl || gpio_chg !== m_chg) begin
                n_err++; bad++;
                if (bad < 10) $display("FAIL random cycle %0d: gpio_o=%h chg=%b, model %h/%b",
                                       i, gpio_o, gpio_chg, m_lvl, m_chg);
            end
`ifdef GPIO_EDGE_DETECT_EN
            n_cmp++;
            if (gpio_rise !== m_rise || gpio_fall !== m_fall) begin
                n_err++; bad++;
                if (bad < 10) $display("FAIL random_edges cycle %0d: rise=%h fall=%h, model %h/%h",
                                       i, gpio_rise, gpio_fall, m_rise, m_fall);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_mask();
        test_multi_bit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
